// File: rtl/psum_seq_ctrl_if.sv
// Command, row-request and psum-store bundle around psum_seq_ctrl.
// slave = sequencer side, master = layer controller / array / store side.
interface psum_seq_ctrl_if #(
    parameter int ADDR_W = 7,
    parameter int PASS_W = 8
);
    logic              start;
    logic [ADDR_W:0]   num_rows;
    logic [PASS_W-1:0] num_passes;
    logic              array_ready;
    logic              din_req;
    logic              buffer_sel;
    logic              first_psum;
    logic [ADDR_W-1:0] psum_prev_addr;
    logic [ADDR_W-1:0] psum_addr;
    logic              psum_en;
    logic              psum_we;
    logic              out_valid;
    logic [ADDR_W-1:0] out_row;
    logic              busy;
    logic              done;

    modport slave (
        input  start, num_rows, num_passes, array_ready,
        output din_req, buffer_sel, first_psum, psum_prev_addr, psum_addr,
               psum_en, psum_we, out_valid, out_row, busy, done
    );

    modport master (
        output start, num_rows, num_passes, array_ready,
        input  din_req, buffer_sel, first_psum, psum_prev_addr, psum_addr,
               psum_en, psum_we, out_valid, out_row, busy, done
    );
endinterface

// File: rtl/psum_seq_ctrl.sv
// Ping-pong psum accumulate sequencer with final readout sweep; PSUM_SEQ_PERF_EN adds perf counters.
// Write lands 2 cycles after din_req, out_valid RD_LAT after read addr; array_ready=0 stalls issue, readout never stalls.
module psum_seq_ctrl #(
    parameter int ADDR_W = 7,
    parameter int PASS_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    psum_seq_ctrl_if.slave bus
`ifdef PSUM_SEQ_PERF_EN
    ,
    output logic [31:0] o_perf_busy_cycles,
    output logic [31:0] o_perf_stall_cycles
`endif
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_FLUSH,
        S_READOUT,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0]   ROW_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [PASS_W-1:0] PASS_ONE = {{(PASS_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    logic [ADDR_W:0]   r_num_rows;
    logic [PASS_W-1:0] r_num_passes;
    logic [PASS_W-1:0] r_pass;
    logic [ADDR_W:0]   r_row;
    logic [ADDR_W:0]   r_rd_cnt;
    logic              r_buf;
    logic              r_s1_vld;
    logic              r_s1_first;
    logic [ADDR_W-1:0] r_s1_row;
    logic              r_s2_vld;
    logic [ADDR_W-1:0] r_s2_row;
    logic [RD_LAT-1:0] r_ov_pipe;
    logic [ADDR_W-1:0] r_orow_pipe [RD_LAT];

    logic              w_issue;
    logic              w_rd_issue;
    logic [ADDR_W:0]   w_row_nxt;
    logic              w_last_pass;
    logic              w_last_out;

    assign w_issue     = (r_state == S_ACCUM) && bus.array_ready;
    assign w_rd_issue  = (r_state == S_READOUT) && (r_rd_cnt < r_num_rows);
    assign w_row_nxt   = r_row + ROW_ONE;
    assign w_last_pass = (r_pass == (r_num_passes - PASS_ONE));
    assign w_last_out  = r_ov_pipe[RD_LAT-1] &&
                         ({1'b0, r_orow_pipe[RD_LAT-1]} == (r_num_rows - ROW_ONE));

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state      <= S_IDLE;
            r_num_rows   <= '0;
            r_num_passes <= '0;
            r_pass       <= '0;
            r_row        <= '0;
            r_rd_cnt     <= '0;
            r_buf        <= 1'b0;
            r_s1_vld     <= 1'b0;
            r_s1_first   <= 1'b0;
            r_s1_row     <= '0;
            r_s2_vld     <= 1'b0;
            r_s2_row     <= '0;
            r_ov_pipe    <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_orow_pipe[i] <= '0;
            end
        end else begin
            // Write pipeline advances every cycle; bubbles travel as vld=0.
            r_s1_vld   <= w_issue;
            r_s1_first <= w_issue && (r_pass == '0);
            r_s1_row   <= r_row[ADDR_W-1:0];
            r_s2_vld   <= r_s1_vld;
            r_s2_row   <= r_s1_row;

            for (int i = RD_LAT - 1; i > 0; i--) begin
                r_ov_pipe[i]   <= r_ov_pipe[i-1];
                r_orow_pipe[i] <= r_orow_pipe[i-1];
            end
            r_ov_pipe[0]   <= w_rd_issue;
            r_orow_pipe[0] <= r_rd_cnt[ADDR_W-1:0];

            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if ((bus.num_rows == '0) || (bus.num_passes == '0)) begin
                            r_state <= S_DONE;
                        end else begin
                            r_num_rows   <= bus.num_rows;
                            r_num_passes <= bus.num_passes;
                            r_pass       <= '0;
                            r_row        <= '0;
                            r_buf        <= 1'b0;
                            r_state      <= S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
                    if (bus.array_ready) begin
                        r_row <= w_row_nxt;
                        if (w_row_nxt == r_num_rows) begin
                            r_state <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    // Leaving once stage 1 is empty keeps buffer_sel stable through the last write.
                    if (!r_s1_vld) begin
                        if (w_last_pass) begin
                            r_rd_cnt <= '0;
                            r_state  <= S_READOUT;
                        end else begin
                            r_pass  <= r_pass + PASS_ONE;
                            r_buf   <= ~r_buf;
                            r_row   <= '0;
                            r_state <= S_ACCUM;
                        end
                    end
                end
                S_READOUT: begin
                    if (w_rd_issue) begin
                        r_rd_cnt <= r_rd_cnt + ROW_ONE;
                    end else if (w_last_out) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.din_req        = w_issue;
    assign bus.psum_prev_addr = r_row[ADDR_W-1:0];
    assign bus.first_psum     = r_s1_first;
    assign bus.psum_we        = r_s2_vld;
    assign bus.psum_addr      = (r_state == S_READOUT) ? r_rd_cnt[ADDR_W-1:0] : r_s2_row;
    assign bus.psum_en        = w_issue | r_s1_vld | r_s2_vld | w_rd_issue;
    assign bus.buffer_sel     = r_buf;
    assign bus.out_valid      = r_ov_pipe[RD_LAT-1];
    assign bus.out_row        = r_orow_pipe[RD_LAT-1];
    assign bus.busy           = (r_state != S_IDLE);
    assign bus.done           = (r_state == S_DONE);

`ifdef PSUM_SEQ_PERF_EN
    logic [31:0] r_perf_busy;
    logic [31:0] r_perf_stall;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_perf_busy  <= '0;
            r_perf_stall <= '0;
        end else if ((r_state == S_IDLE) && bus.start) begin
            r_perf_busy  <= '0;
            r_perf_stall <= '0;
        end else begin
            if ((r_state != S_IDLE) && (r_perf_busy != '1)) begin
                r_perf_busy <= r_perf_busy + 32'd1;
            end
            if ((r_state == S_ACCUM) && !bus.array_ready && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign o_perf_busy_cycles  = r_perf_busy;
    assign o_perf_stall_cycles = r_perf_stall;
`endif
endmodule

// File: tb/tb_psum_seq_ctrl.sv
// Bench for psum_seq_ctrl: per-cycle schedule model plus a two-bank psum store model fed by the DUT.
`timescale 1ns/1ps
module tb_psum_seq_ctrl;
    localparam int ADDR_W = 7;
    localparam int PASS_W = 8;
    localparam int MAXC   = 2048;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    psum_seq_ctrl_if #(.ADDR_W(ADDR_W), .PASS_W(PASS_W)) bus ();
`ifdef PSUM_SEQ_PERF_EN
    logic [31:0] perf_busy;
    logic [31:0] perf_stall;
`endif

    psum_seq_ctrl #(.ADDR_W(ADDR_W), .PASS_W(PASS_W), .RD_LAT(1)) dut (
        .i_clk (clk),
        .i_rstn(rstn),
        .bus   (bus)
`ifdef PSUM_SEQ_PERF_EN
        ,
        .o_perf_busy_cycles (perf_busy),
        .o_perf_stall_cycles(perf_stall)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit chk_on = 0;
    int exp_np = 1;

    // Expected per-cycle schedule, indexed by absolute cycle.
    int e_req [MAXC];
    int e_prev [MAXC];
    int e_first [MAXC];
    int e_we [MAXC];
    int e_en [MAXC];
    int e_acare [MAXC];
    int e_addr [MAXC];
    int e_bcare [MAXC];
    int e_bsel [MAXC];
    int e_ov [MAXC];
    int e_orow [MAXC];
    int e_busy [MAXC];
    int e_done [MAXC];
    int e_zero [MAXC];
    int rdy_pat [MAXC];

    int mem [2][128];
    bit seeded = 0;
    int rd_prev_q, op_q, d1, d2, rd_q;
    int cap [128];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, expv);
        end
    endtask

    // Psum store + array model: array returns row+1 two cycles after each request.
    always @(posedge clk) begin
        if (!seeded) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < 128; i++)
                    mem[b][i] <= 1000 + 3 * i + 17 * b;
            seeded <= 1'b1;
        end else begin
            rd_prev_q <= mem[int'(!bus.buffer_sel)][int'(bus.psum_prev_addr)];
            op_q      <= bus.first_psum ? 0 : rd_prev_q;
            d1        <= int'(bus.psum_prev_addr) + 1;
            d2        <= d1;
            if (bus.psum_en && bus.psum_we)
                mem[int'(bus.buffer_sel)][int'(bus.psum_addr)] <= d2 + op_q;
            rd_q <= mem[int'(bus.buffer_sel)][int'(bus.psum_addr)];
        end
    end

    always @(negedge clk) begin
        if (chk_on && cyc < MAXC) begin
            chk("din_req",    int'(bus.din_req),    e_req[cyc]);
            chk("first_psum", int'(bus.first_psum), e_first[cyc]);
            chk("psum_we",    int'(bus.psum_we),    e_we[cyc]);
            chk("psum_en",    int'(bus.psum_en),    e_en[cyc]);
            chk("out_valid",  int'(bus.out_valid),  e_ov[cyc]);
            chk("busy",       int'(bus.busy),       e_busy[cyc]);
            chk("done",       int'(bus.done),       e_done[cyc]);
            if (e_req[cyc] != 0)   chk("prev_addr",  int'(bus.psum_prev_addr), e_prev[cyc]);
            if (e_acare[cyc] != 0) chk("psum_addr",  int'(bus.psum_addr),      e_addr[cyc]);
            if (e_bcare[cyc] != 0) chk("buffer_sel", int'(bus.buffer_sel),     e_bsel[cyc]);
            if (e_ov[cyc] != 0) begin
                chk("out_row",  int'(bus.out_row), e_orow[cyc]);
                chk("out_data", rd_q, exp_np * (e_orow[cyc] + 1));
            end
            if (e_zero[cyc] != 0) begin
                chk("zero_prev_addr",  int'(bus.psum_prev_addr), 0);
                chk("zero_psum_addr",  int'(bus.psum_addr),      0);
                chk("zero_out_row",    int'(bus.out_row),        0);
                chk("zero_buffer_sel", int'(bus.buffer_sel),     0);
            end
            if (bus.out_valid) cap[int'(bus.out_row)] = rd_q;
        end
    end

    task automatic clear_from(input int c);
        for (int k = c; k < MAXC; k++) begin
            e_req[k] = 0; e_prev[k] = 0; e_first[k] = 0; e_we[k] = 0; e_en[k] = 0;
            e_acare[k] = 0; e_addr[k] = 0; e_bcare[k] = 0; e_bsel[k] = 0; e_ov[k] = 0;
            e_orow[k] = 0; e_busy[k] = 0; e_done[k] = 0; e_zero[k] = 0;
        end
    endtask

    // Schedule from the rules: rows issue on ready cycles, write 2 later,
    // next pass 3 cycles after the last issue, then a stall-free sweep.
    task automatic build(input int c0, input int nr, input int np,
                         output int tdone, output int stalls, output int busyc);
        int t, tl, tf;
        stalls = 0;
        if (nr == 0 || np == 0) begin
            e_done[c0+1] = 1;
            e_busy[c0+1] = 1;
            tdone = c0 + 1;
            busyc = 1;
            return;
        end
        t = c0 + 1;
        for (int p = 0; p < np; p++) begin
            tf = t;
            for (int r = 0; r < nr; r++) begin
                while (rdy_pat[t] == 0) begin t++; stalls++; end
                e_req[t] = 1; e_prev[t] = r; e_en[t] = 1;
                e_first[t+1] = (p == 0) ? 1 : 0; e_en[t+1] = 1;
                e_we[t+2] = 1; e_en[t+2] = 1; e_acare[t+2] = 1; e_addr[t+2] = r;
                t++;
            end
            tl = t - 1;
            for (int k = tf; k <= tl + 2; k++) begin e_bcare[k] = 1; e_bsel[k] = p % 2; end
            t = tl + 3;
        end
        for (int r = 0; r < nr; r++) begin
            e_en[t+r] = 1; e_acare[t+r] = 1; e_addr[t+r] = r;
            e_ov[t+r+1] = 1; e_orow[t+r+1] = r;
        end
        tdone = t + nr + 1;
        e_done[tdone] = 1;
        for (int k = t; k <= tdone + 1; k++) begin e_bcare[k] = 1; e_bsel[k] = (np - 1) % 2; end
        for (int k = c0 + 1; k <= tdone; k++) e_busy[k] = 1;
        busyc = tdone - c0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input int nr, input int np, output int c0,
                           output int tdone, output int stalls, output int busyc);
        tick();
        c0 = cyc;
        bus.start      = 1'b1;
        bus.num_rows   = nr[ADDR_W:0];
        bus.num_passes = np[PASS_W-1:0];
        exp_np = np;
        build(c0, nr, np, tdone, stalls, busyc);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, output int tseen);
        int n;
        n = 0;
        while (!bus.done && n < 2000) begin tick(); n++; end
        chk(name, int'(bus.done), 1);
        tseen = cyc;
        tick();
        tick();
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1 bus.array_ready = (rdy_pat[cyc] != 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, tdone, stalls, busyc, tseen;
        for (int k = 0; k < MAXC; k++) rdy_pat[k] = 1;
        clear_from(0);
        bus.start = 1'b0; bus.num_rows = '0; bus.num_passes = '0; bus.array_ready = 1'b1;
        rstn = 1'b0;
        tick();
        e_zero[cyc] = 1; e_zero[cyc+1] = 1; e_zero[cyc+2] = 1;
        chk_on = 1;
        tick();
        tick();
        rstn = 1'b1;
        tick();

        // Single pass, no stalls.
        run_job(4, 1, c0, tdone, stalls, busyc);
        wait_done("t1_done_seen", tseen);
        chk("t1_latency", tseen - c0, 12);
        chk("t1_row3", cap[3], 4);

        // Three passes alternate buffers and sum 3*(row+1).
        run_job(3, 3, c0, tdone, stalls, busyc);
        wait_done("t2_done_seen", tseen);
        chk("t2_row0", cap[0], 3);
        chk("t2_row1", cap[1], 6);
        chk("t2_row2", cap[2], 9);

        // Two stall cycles mid pass 0, plus a start while busy that must be ignored.
        rdy_pat[cyc+4] = 0;
        rdy_pat[cyc+5] = 0;
        run_job(4, 2, c0, tdone, stalls, busyc);
        chk("t3_model_stalls", stalls, 2);
        repeat (9) tick();
        bus.start = 1'b1; bus.num_rows = 8'd7; bus.num_passes = 8'd1;
        tick();
        bus.start = 1'b0;
        wait_done("t3_done_seen", tseen);
        chk("t3_latency", tseen - c0, 20);
        chk("t3_row3", cap[3], 8);
`ifdef PSUM_SEQ_PERF_EN
        chk("t3_perf_stall", int'(perf_stall), 2);
        chk("t3_perf_busy", int'(perf_busy), busyc);
`endif

        // Zero-sized jobs finish next cycle with no BRAM traffic.
        run_job(0, 5, c0, tdone, stalls, busyc);
        wait_done("t4_done_seen", tseen);
        chk("t4_latency", tseen - c0, 1);
        run_job(2, 0, c0, tdone, stalls, busyc);
        wait_done("t4b_done_seen", tseen);
        chk("t4b_latency", tseen - c0, 1);

        // Reset during pass 1, then a fresh job.
        run_job(4, 2, c0, tdone, stalls, busyc);
        repeat (7) tick();
        rstn = 1'b0;
        clear_from(cyc + 1);
        e_zero[cyc+1] = 1; e_zero[cyc+2] = 1;
        tick();
        rstn = 1'b1;
        chk("t5_rst_busy", int'(bus.busy), 0);
        tick();
        tick();
        run_job(5, 2, c0, tdone, stalls, busyc);
        wait_done("t5_done_seen", tseen);
        chk("t5_latency", tseen - c0, 21);
        chk("t5_row4", cap[4], 10);

        // Full-depth buffer.
        run_job(128, 1, c0, tdone, stalls, busyc);
        wait_done("t6_done_seen", tseen);
        chk("t6_latency", tseen - c0, 260);
        chk("t6_row127", cap[127], 128);

        chk_on = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
